// File: rtl/rx_uart.sv
// UART receiver: 2-flop synchronizer, oversampled start-bit validation, LSB-first payload
// capture and stop-bit check. Each frame is reported with a one-clk o_valid strobe.
module rx_uart #(
    parameter int unsigned INPUT_DATA_WIDTH = 8,
    parameter int unsigned PARITY_ENABLED   = 1,
    parameter int unsigned PARITY_ODD       = 0,
    parameter int unsigned OVERSAMPLE       = 16,
    localparam int unsigned W = INPUT_DATA_WIDTH + PARITY_ENABLED
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         sample_tick,
    input  logic         serial_in,
    output logic [W-1:0] o_data,
    output logic         o_valid,
    output logic         o_parity_err,
    output logic         o_frame_err,
    output logic         o_busy
);

    localparam int unsigned TW = (OVERSAMPLE > 1) ? $clog2(OVERSAMPLE) : 1;
    localparam int unsigned BW = $clog2(W + 1);
    localparam logic [TW-1:0] HalfTick = TW'(OVERSAMPLE / 2 - 1);
    localparam logic [TW-1:0] LastTick = TW'(OVERSAMPLE - 1);
    localparam logic [BW-1:0] LastBit  = BW'(W - 1);
    localparam logic ParityEn  = (PARITY_ENABLED != 0);
    localparam logic ParityOdd = PARITY_ODD[0];

    typedef enum logic [2:0] {StIdle, StStart, StData, StStop, StBreak} state_e;

    state_e          state_q, state_d;
    logic [TW-1:0]   tick_q, tick_d;
    logic [BW-1:0]   bit_q, bit_d;
    logic [W-1:0]    shift_q, shift_d;
    logic            sync1_q, rx_s;
    logic            done;
    logic [W-1:0]    data_q;
    logic            valid_q, perr_q, ferr_q;

    always_comb begin
        state_d = state_q;
        tick_d  = tick_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        done    = 1'b0;
        if (sample_tick) begin
            unique case (state_q)
                StIdle: begin
                    if (!rx_s) begin
                        state_d = StStart;
                        tick_d  = '0;
                    end
                end
                StStart: begin
                    // Mid start bit: a line already back high was only a glitch.
                    if (tick_q == HalfTick) begin
                        tick_d  = '0;
                        bit_d   = '0;
                        state_d = rx_s ? StIdle : StData;
                    end else begin
                        tick_d = tick_q + 1'b1;
                    end
                end
                StData: begin
                    if (tick_q == LastTick) begin
                        tick_d  = '0;
                        shift_d = {rx_s, shift_q[W-1:1]};
                        bit_d   = bit_q + 1'b1;
                        if (bit_q == LastBit) begin
                            state_d = StStop;
                        end
                    end else begin
                        tick_d = tick_q + 1'b1;
                    end
                end
                StStop: begin
                    if (tick_q == LastTick) begin
                        tick_d  = '0;
                        done    = 1'b1;
                        state_d = rx_s ? StIdle : StBreak;
                    end else begin
                        tick_d = tick_q + 1'b1;
                    end
                end
                StBreak: begin
                    // Wait for the line to return high so a held-low line cannot retrigger.
                    if (rx_s) begin
                        state_d = StIdle;
                    end
                end
                default: state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_q <= 1'b1;
            rx_s    <= 1'b1;
            state_q <= StIdle;
            tick_q  <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            perr_q  <= 1'b0;
            ferr_q  <= 1'b0;
        end else begin
            sync1_q <= serial_in;
            rx_s    <= sync1_q;
            state_q <= state_d;
            tick_q  <= tick_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            valid_q <= done;
            if (done) begin
                data_q <= shift_q;
                ferr_q <= ~rx_s;
                perr_q <= ParityEn & ((^shift_q) ^ ParityOdd);
            end
        end
    end

    assign o_data       = data_q;
    assign o_valid      = valid_q;
    assign o_parity_err = perr_q;
    assign o_frame_err  = ferr_q;
    assign o_busy       = (state_q != StIdle);

endmodule
